cpu_run_controller: RTL and testbench

//   Synthesizable bring-up sequencer for the CPU. Replaces hand-written reset/run/interrupt sequencing in benches.
//   On start it holds the CPU in reset for a programmable time, releases it, and lets it run for a fixed cycle budget.

---
 rtl/cpu_run_controller.sv | 162 ++++++++++++++++
 tb/tb_cpu_run_controller.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// Bring-up sequencer: holds the CPU in reset, runs it for a fixed budget,
// injects interrupt pulses on request and traces OUT-port changes with the PC.
module cpu_run_controller #(
   parameter int DATA_W       = 8,
   parameter int PC_W         = 8,
   parameter int RESET_CYCLES = 3,
   parameter int RUN_CYCLES   = 30,
   parameter int INTR_PULSE   = 1,
   parameter int TRACE_DEPTH  = 16,
   parameter int CNT_W        = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           intr_req,
   input  logic [PC_W-1:0]                cpu_pc,
   input  logic [DATA_W-1:0]              cpu_out,
   output logic                           cpu_reset,
   output logic                           cpu_interrupt,
   input  logic                           trace_rd,
   output logic                           trace_valid,
   output logic [PC_W+DATA_W-1:0]         trace_data,
   output logic [$clog2(TRACE_DEPTH):0]   trace_count,
   output logic                           trace_overflow,
   output logic                           busy,
   output logic                           done,
   output logic [CNT_W-1:0]               cycle_count
);
   localparam int AW = $clog2(TRACE_DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = $clog2(RESET_CYCLES + 1);
   localparam int IW = $clog2(INTR_PULSE + 1);
   localparam int EW = PC_W + DATA_W;

   typedef enum logic [1:0] {IDLE, RESET_HOLD, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [IW-1:0]     ipls_q, ipls_d;
   logic              intr_q, intr_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] prev_out_q, prev_out_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [EW-1:0]     mem_q [TRACE_DEPTH];
   logic              clear, wr_req, do_rd, do_wr;

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      ipls_d     = ipls_q;
      intr_d     = intr_q;
      cnt_d      = cnt_q;
      prev_out_d = cpu_out;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      clear      = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RESET_HOLD;
               hold_d  = '0;
               clear   = 1'b1;
            end
         end
         RESET_HOLD: begin
            if (hold_q == HW'(RESET_CYCLES - 1)) state_d = RUN;
            else                                 hold_d  = hold_q + HW'(1);
         end
         RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(RUN_CYCLES - 1)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      // Pulse only survives while staying in RUN; leaving RUN truncates it.
      if (state_q != RUN || state_d != RUN) begin
         intr_d = 1'b0;
         ipls_d = '0;
      end else if (intr_q) begin
         if (ipls_q == '0) intr_d = 1'b0;
         else              ipls_d = ipls_q - IW'(1);
      end else if (intr_req) begin
         intr_d = 1'b1;
         ipls_d = IW'(INTR_PULSE - 1);
      end

      wr_req = (state_q == RUN) && ((cnt_q == '0) || (cpu_out != prev_out_q));
      do_rd  = trace_rd && (count_q != '0);
      do_wr  = wr_req && ((count_q != CW'(TRACE_DEPTH)) || do_rd);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(do_wr) - CW'(do_rd);
      ovf_d   = ovf_q | (wr_req & ~do_wr);

      if (clear) begin
         cnt_d    = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end

      cpu_reset_d = (state_d != RUN);
      busy_d      = (state_d == RESET_HOLD) || (state_d == RUN);
      done_d      = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         ipls_q      <= '0;
         intr_q      <= 1'b0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cnt_q       <= '0;
         prev_out_q  <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         ipls_q      <= ipls_d;
         intr_q      <= intr_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cnt_q       <= cnt_d;
         prev_out_q  <= prev_out_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && do_wr) mem_q[wr_ptr_q] <= {cpu_pc, cpu_out};
   end

   assign cpu_reset      = cpu_reset_q;
   assign cpu_interrupt  = intr_q;
   assign trace_valid    = (count_q != '0);
   assign trace_data     = mem_q[rd_ptr_q];
   assign trace_count    = count_q;
   assign trace_overflow = ovf_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign cycle_count    = cnt_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench: default-parameter instance plus a TRACE_DEPTH=4 / INTR_PULSE=2
// instance sharing the same stimulus stream.
module tb_cpu_run_controller;
   logic        clk = 1'b0;
   logic        reset, start, intr_req, rd_a, rd_b;
   logic [7:0]  cpu_pc, cpu_out;

   logic        rst_a, int_a, val_a, ovf_a, busy_a, done_a;
   logic [15:0] data_a, cyc_a;
   logic [4:0]  cnt_a;
   logic        rst_b, int_b, val_b, ovf_b, busy_b, done_b;
   logic [15:0] data_b, cyc_b;
   logic [2:0]  cnt_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_run_controller u_a (
      .clk(clk), .reset(reset), .start(start), .intr_req(intr_req),
      .cpu_pc(cpu_pc), .cpu_out(cpu_out), .cpu_reset(rst_a), .cpu_interrupt(int_a),
      .trace_rd(rd_a), .trace_valid(val_a), .trace_data(data_a), .trace_count(cnt_a),
      .trace_overflow(ovf_a), .busy(busy_a), .done(done_a), .cycle_count(cyc_a)
   );

   cpu_run_controller #(.TRACE_DEPTH(4), .INTR_PULSE(2)) u_b (
      .clk(clk), .reset(reset), .start(start), .intr_req(intr_req),
      .cpu_pc(cpu_pc), .cpu_out(cpu_out), .cpu_reset(rst_b), .cpu_interrupt(int_b),
      .trace_rd(rd_b), .trace_valid(val_b), .trace_data(data_b), .trace_count(cnt_b),
      .trace_overflow(ovf_b), .busy(busy_b), .done(done_b), .cycle_count(cyc_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; intr_req = 1'b0; rd_a = 1'b0; rd_b = 1'b0;
      cpu_pc = 8'h00; cpu_out = 8'h00;
      tick(); tick(); tick();
      chk("rst_cpu_reset", rst_a, 1);
      chk("rst_intr", int_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_cycles", cyc_a, 0);
      chk("rst_valid", val_a, 0);
      chk("rst_count", cnt_a, 0);
      chk("rst_ovf", ovf_a, 0);

      reset = 1'b0; intr_req = 1'b1;
      tick();
      chk("idle_intr_a", int_a, 0);
      chk("idle_intr_b", int_b, 0);
      chk("idle_cpu_reset", rst_a, 1);
      intr_req = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("hold_busy", busy_a, 1);
      for (int i = 0; i < 3; i++) begin
         chk("hold_cpu_reset", rst_a, 1);
         tick();
      end

      for (int n = 0; n < 30; n++) begin
         chk("run_cpu_reset", rst_a, 0);
         chk("run_cycles", cyc_a, 32'(n));
         cpu_pc = 8'(n);
         case (n)
            0, 1:       cpu_out = 8'h00;
            2, 3:       cpu_out = 8'h05;
            4, 5, 6, 7: cpu_out = 8'h07;
            8:          cpu_out = 8'h08;
            9:          cpu_out = 8'h09;
            10:         cpu_out = 8'h0a;
            default:    cpu_out = 8'h0b;
         endcase
         rd_a     = (n >= 5 && n <= 7);
         rd_b     = (n >= 11 && n <= 15);
         intr_req = (n == 5 || n == 6);
         start    = (n == 20);
         if (n == 5)  begin chk("a_count3", cnt_a, 3); chk("a_rd0", data_a, 16'h0000); end
         if (n == 6)  begin chk("a_rd1", data_a, 16'h0205); chk("b_intr6", int_b, 1); chk("a_intr6", int_a, 1); end
         if (n == 7)  begin chk("a_rd2", data_a, 16'h0407); chk("b_intr7", int_b, 1); chk("a_intr7", int_a, 0); end
         if (n == 8)  begin chk("a_count0", cnt_a, 0); chk("a_valid0", val_a, 0); chk("b_intr8", int_b, 0); chk("b_count3", cnt_b, 3); end
         if (n == 9)  begin chk("b_full", cnt_b, 4); chk("b_ovf_pre", ovf_b, 0); end
         if (n == 10) begin chk("b_ovf_set", ovf_b, 1); chk("b_full_hold", cnt_b, 4); end
         if (n == 11) begin chk("b_head0", data_b, 16'h0000); chk("b_cnt11", cnt_b, 4); end
         if (n == 12) begin chk("b_rw_cnt", cnt_b, 4); chk("b_head1", data_b, 16'h0205); end
         if (n == 13) chk("b_head2", data_b, 16'h0407);
         if (n == 14) chk("b_head3", data_b, 16'h0808);
         if (n == 15) chk("b_head4", data_b, 16'h0b0b);
         if (n == 16) begin chk("b_empty", cnt_b, 0); chk("b_valid0", val_b, 0); chk("b_ovf_sticky", ovf_b, 1); end
         tick();
      end
      rd_a = 1'b0; rd_b = 1'b0; intr_req = 1'b0; start = 1'b0;

      chk("done_flag", done_a, 1);
      chk("done_cycles", cyc_a, 30);
      chk("done_busy", busy_a, 0);
      chk("done_cpu_reset", rst_a, 1);
      chk("done_intr", int_b, 0);
      chk("done_a_count", cnt_a, 4);
      chk("done_a_head", data_a, 16'h0808);
      rd_a = 1'b1; intr_req = 1'b1;
      tick();
      rd_a = 1'b0; intr_req = 1'b0;
      chk("done_rd_head", data_a, 16'h0909);
      chk("done_rd_count", cnt_a, 3);
      chk("done_req_a", int_a, 0);
      chk("done_req_b", int_b, 0);
      chk("done_stays", done_a, 1);

      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rerun_count", cnt_a, 0);
      chk("rerun_valid", val_a, 0);
      chk("rerun_ovf_b", ovf_b, 0);
      chk("rerun_cycles", cyc_a, 0);
      chk("rerun_busy", busy_a, 1);
      chk("rerun_done", done_a, 0);
      chk("rerun_cpu_reset", rst_a, 1);
      tick(); tick(); tick();
      chk("rerun_run0", rst_a, 0);
      for (int n = 0; n < 10; n++) begin
         intr_req = (n == 9);
         tick();
      end
      intr_req = 1'b0;
      chk("r10_cycles", cyc_a, 10);
      chk("r10_intr_a", int_a, 1);
      chk("r10_intr_b", int_b, 1);
      chk("r10_count", cnt_a, 1);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_cpu_reset", rst_a, 1);
      chk("abort_intr_a", int_a, 0);
      chk("abort_intr_b", int_b, 0);
      chk("abort_valid", val_a, 0);
      chk("abort_count", cnt_a, 0);
      chk("abort_done", done_a, 0);
      chk("abort_busy", busy_a, 0);
      chk("abort_cycles", cyc_a, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
